// File: rtl/pp_pkg.sv
// Shared constants for the ping-pong FIFO write/read schedulers.
package pp_pkg;

   typedef enum logic [1:0] {
      FILL1 = 2'd0,
      FILL2 = 2'd1,
      STALL = 2'd2
   } pp_state_t;

   localparam int PP_DATA_W  = 16;
   localparam int PP_DEPTH   = 16;
   localparam int PP_LEN_W   = 5;
   localparam int PP_TIMEOUT = 1000;
   localparam int PP_DROP_W  = 16;

   function automatic pp_state_t fill_state(input logic bank);
      return bank ? FILL2 : FILL1;
   endfunction

endpackage

// File: rtl/pp_bank_tracker.sv
// Per-bank word count and sealed flag, with seal-on-full and release qualification.
module pp_bank_tracker
   import pp_pkg::*;
#(
   parameter int DEPTH = PP_DEPTH,
   parameter int LEN_W = PP_LEN_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             wr,
   input  logic             seal_req,
   input  logic             rel,
   output logic [LEN_W-1:0] len,
   output logic             sealed,
   output logic             seal_now,
   output logic             rel_ok
);

   logic full_hit;

   assign full_hit = wr && (len == LEN_W'(DEPTH - 1));
   assign seal_now = en && (full_hit || seal_req);
   // A release only counts for a sealed bank, and loses to a seal on the same edge.
   assign rel_ok   = en && rel && sealed && !seal_now;

   always_ff @(posedge clk) begin
      if (rst) begin
         len    <= '0;
         sealed <= 1'b0;
      end else if (en) begin
         if (rel_ok) begin
            len    <= '0;
            sealed <= 1'b0;
         end else begin
            if (wr)       len    <= len + 1'b1;
            if (seal_now) sealed <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/pingpong_wr_sched.sv
// Write-side scheduler for the two-bank ping-pong FIFO pair; bank_release is the reader's drain pulse.
// Optional idle-timeout flush of a partial bank is built when PP_TIMEOUT_FLUSH_EN is defined.
module pingpong_wr_sched
   import pp_pkg::*;
#(
   parameter int DATA_W  = PP_DATA_W,
   parameter int DEPTH   = PP_DEPTH,
   parameter int LEN_W   = PP_LEN_W,
   parameter int TIMEOUT = PP_TIMEOUT,
   parameter int DROP_W  = PP_DROP_W
) (
   input  logic              sysclk,
   input  logic              rst,
   input  logic              locked,
   input  logic [DATA_W-1:0] data_in,
   input  logic              fill_data,
   input  logic [1:0]        fifo_full,
   input  logic [1:0]        bank_release,
   output logic [DATA_W-1:0] din,
   output logic              wr_en1,
   output logic              wr_en2,
   output logic [1:0]        sealed,
   output logic [LEN_W-1:0]  len1,
   output logic [LEN_W-1:0]  len2,
   output logic [DROP_W-1:0] drop_cnt,
   output logic              stall
);

   if (DEPTH < 2 || (2 ** LEN_W) <= DEPTH || TIMEOUT < 1) begin : g_bad_cfg
      $error("pingpong_wr_sched: inconsistent DEPTH/LEN_W/TIMEOUT");
   end

   pp_state_t               state;
   logic                    act, in_fill, act_full;
   logic                    accept, guard, drop, tmo_seal;
   logic [1:0]              seal_req, seal_now, rel_ok;
   logic [1:0][LEN_W-1:0]   len;
   logic                    pend_vld, pend_bank;
   logic [DATA_W-1:0]       pend_data;

   assign in_fill  = (state != STALL);
   assign act      = (state == FILL2);
   assign act_full = fifo_full[act];
   assign accept   = locked && in_fill && fill_data && !act_full;
   assign guard    = in_fill && fill_data && act_full;
   assign drop     = locked && fill_data && (!in_fill || act_full);
   assign seal_req = {2{in_fill && (guard || tmo_seal)}} & {act, !act};
   assign len1     = len[0];
   assign len2     = len[1];

   for (genvar b = 0; b < 2; b++) begin : g_bank
      pp_bank_tracker #(.DEPTH(DEPTH), .LEN_W(LEN_W)) u_trk (
         .clk      (sysclk),
         .rst      (rst),
         .en       (locked),
         .wr       (accept && (act == 1'(b))),
         .seal_req (seal_req[b]),
         .rel      (bank_release[b]),
         .len      (len[b]),
         .sealed   (sealed[b]),
         .seal_now (seal_now[b]),
         .rel_ok   (rel_ok[b])
      );
   end

`ifdef PP_TIMEOUT_FLUSH_EN
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   logic [TMR_W-1:0] idle_tmr, tmr_inc;
   logic [LEN_W-1:0] act_len;

   assign act_len  = len[act];
   assign tmr_inc  = idle_tmr + 1'b1;
   // A strobe in the expiry cycle wins; the guard path still seals on its own.
   assign tmo_seal = in_fill && (act_len != '0) && !fill_data && (tmr_inc == TMR_W'(TIMEOUT));

   always_ff @(posedge sysclk) begin
      if (rst)
         idle_tmr <= '0;
      else if (locked) begin
         if (accept || (seal_now != 2'b00) || !in_fill || (act_len == '0))
            idle_tmr <= '0;
         else
            idle_tmr <= tmr_inc;
      end
   end
`else
   assign tmo_seal = 1'b0;
`endif

   // Accepted sample waits one stage in pend_* before reaching the FIFO ports.
   always_ff @(posedge sysclk) begin
      if (rst) begin
         state     <= FILL1;
         stall     <= 1'b0;
         drop_cnt  <= '0;
         pend_vld  <= 1'b0;
         pend_bank <= 1'b0;
         pend_data <= '0;
         wr_en1    <= 1'b0;
         wr_en2    <= 1'b0;
         din       <= '0;
      end else if (!locked) begin
         wr_en1 <= 1'b0;
         wr_en2 <= 1'b0;
      end else begin
         case (state)
            FILL1, FILL2: begin
               if (seal_now[act]) begin
                  if (!sealed[!act] || rel_ok[!act]) begin
                     state <= fill_state(!act);
                     stall <= 1'b0;
                  end else begin
                     state <= STALL;
                     stall <= 1'b1;
                  end
               end
            end
            default: begin
               if (rel_ok[0]) begin
                  state <= FILL1;
                  stall <= 1'b0;
               end else if (rel_ok[1]) begin
                  state <= FILL2;
                  stall <= 1'b0;
               end
            end
         endcase
         if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
         pend_vld <= accept;
         if (accept) begin
            pend_bank <= act;
            pend_data <= data_in;
         end
         wr_en1 <= pend_vld && !pend_bank;
         wr_en2 <= pend_vld && pend_bank;
         if (pend_vld) din <= pend_data;
      end
   end

endmodule

// File: tb/tb_pingpong_wr_sched.sv
// Scoreboard bench for pingpong_wr_sched (DEPTH=16, TIMEOUT=100, 4-bit drop counter).
module tb_pingpong_wr_sched;

   localparam int DW = 16, DEPTH = 16, LW = 5, TMO = 100, DRW = 4;

   logic          sysclk = 1'b0, rst = 1'b1, locked = 1'b0, fill_data = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic [1:0]    fifo_full = '0, bank_release = '0;
   logic [DW-1:0] din;
   logic          wr_en1, wr_en2, stall;
   logic [1:0]    sealed;
   logic [LW-1:0] len1, len2;
   logic [DRW-1:0] drop_cnt;

   int checks = 0, errors = 0, cyc = 0;

   typedef struct {
      int            bank;
      logic [DW-1:0] data;
      int            due;
   } exp_t;
   exp_t sb[$];

   pingpong_wr_sched #(.DATA_W(DW), .DEPTH(DEPTH), .LEN_W(LW), .TIMEOUT(TMO), .DROP_W(DRW)) dut (
      .sysclk(sysclk), .rst(rst), .locked(locked), .data_in(data_in), .fill_data(fill_data),
      .fifo_full(fifo_full), .bank_release(bank_release), .din(din), .wr_en1(wr_en1),
      .wr_en2(wr_en2), .sealed(sealed), .len1(len1), .len2(len2), .drop_cnt(drop_cnt),
      .stall(stall)
   );

   always #5 sysclk = ~sysclk;
   always @(posedge sysclk) cyc <= cyc + 1;

   // Write monitor: every FIFO write must match the oldest expected sample, on its due edge.
   always @(negedge sysclk) begin
      exp_t e;
      if (wr_en1 || wr_en2) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write cyc=%0d wr_en1=%b wr_en2=%b din=%0d", cyc, wr_en1, wr_en2, din);
         end else begin
            e = sb.pop_front();
            if ((wr_en1 && wr_en2) || (wr_en2 != (e.bank == 1)) || din !== e.data || cyc != e.due) begin
               errors++;
               $display("FAIL write got wr_en1=%b wr_en2=%b din=%0d cyc=%0d want bank=%0d din=%0d cyc=%0d",
                        wr_en1, wr_en2, din, cyc, e.bank + 1, e.data, e.due);
            end
         end
      end else if (sb.size() > 0 && sb[0].due < cyc) begin
         checks++;
         errors++;
         e = sb.pop_front();
         $display("FAIL missing_write bank=%0d din=%0d due=%0d now=%0d", e.bank + 1, e.data, e.due, cyc);
      end
   end

   task automatic send(input logic [DW-1:0] d, input int bank);
      exp_t e;
      @(negedge sysclk);
      fill_data = 1'b1;
      data_in   = d;
      if (bank >= 0) begin
         e.bank = bank; e.data = d; e.due = cyc + 2;
         sb.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge sysclk);
         fill_data    = 1'b0;
         bank_release = 2'b00;
      end
   endtask

   task automatic do_reset();
      @(negedge sysclk);
      rst = 1'b1; fill_data = 1'b0; bank_release = 2'b00; fifo_full = 2'b00; locked = 1'b1;
      @(negedge sysclk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge sysclk);
      checks++; if ({wr_en1, wr_en2, stall} !== 3'b000) begin errors++; $display("FAIL reset_strobes got %b want 000", {wr_en1, wr_en2, stall}); end
      checks++; if (din !== '0) begin errors++; $display("FAIL reset_din got %0d want 0", din); end
      checks++; if (sealed !== 2'b00 || len1 !== '0 || len2 !== '0) begin errors++; $display("FAIL reset_banks got sealed=%b len1=%0d len2=%0d want 00 0 0", sealed, len1, len2); end
      checks++; if (drop_cnt !== '0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
      rst = 1'b0; locked = 1'b1;
   endtask

   task automatic test_fill_alternate();
      for (int i = 1; i <= 16; i++) begin
         send(DW'(i), 0);
         checks++; if (len1 !== LW'(i - 1) || sealed !== 2'b00) begin errors++; $display("FAIL fill_len got len1=%0d sealed=%b want %0d 00", len1, sealed, i - 1); end
      end
      send(17, 1);
      checks++; if (sealed !== 2'b01 || len1 !== LW'(16)) begin errors++; $display("FAIL fill_seal got sealed=%b len1=%0d want 01 16", sealed, len1); end
   endtask

   task automatic test_stall_release();
      for (int i = 18; i <= 32; i++) send(DW'(i), 1);
      idle(2);
      checks++; if (sealed !== 2'b11 || stall !== 1'b1 || len2 !== LW'(16)) begin errors++; $display("FAIL stall_enter got sealed=%b stall=%b len2=%0d want 11 1 16", sealed, stall, len2); end
      repeat (3) send(16'hdead, -1);
      idle(1);
      checks++; if (drop_cnt !== DRW'(3) || stall !== 1'b1) begin errors++; $display("FAIL stall_drop got drop=%0d stall=%b want 3 1", drop_cnt, stall); end
      @(negedge sysclk); bank_release = 2'b01;
      idle(1);
      checks++; if (sealed !== 2'b10 || len1 !== '0 || stall !== 1'b0 || len2 !== LW'(16)) begin errors++; $display("FAIL stall_release got sealed=%b len1=%0d stall=%b len2=%0d want 10 0 0 16", sealed, len1, stall, len2); end
      send(100, 0);
   endtask

   task automatic test_simultaneous();
      for (int i = 101; i <= 115; i++) send(DW'(i), 0);
      idle(2);
      checks++; if (sealed !== 2'b11 || stall !== 1'b1) begin errors++; $display("FAIL simul_stall got sealed=%b stall=%b want 11 1", sealed, stall); end
      send(16'hbeef, -1);
      bank_release = 2'b10;
      idle(1);
      checks++; if (drop_cnt !== DRW'(4) || sealed !== 2'b01 || len2 !== '0 || stall !== 1'b0) begin errors++; $display("FAIL simul_release got drop=%0d sealed=%b len2=%0d stall=%b want 4 01 0 0", drop_cnt, sealed, len2, stall); end
      send(200, 1);
   endtask

   task automatic test_drop_saturate();
      for (int i = 201; i <= 215; i++) send(DW'(i), 1);
      idle(2);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sat_stall got %b want 1", stall); end
      repeat (20) send(16'h0bad, -1);
      idle(1);
      checks++; if (drop_cnt !== 4'hf) begin errors++; $display("FAIL drop_saturate got %0d want 15", drop_cnt); end
   endtask

   task automatic test_guard();
      do_reset();
      for (int i = 1; i <= 7; i++) send(DW'(i), 0);
      idle(2);
      fifo_full = 2'b01;
      send(8, -1);
      idle(1);
      checks++; if (drop_cnt !== DRW'(1) || sealed !== 2'b01 || len1 !== LW'(7) || stall !== 1'b0) begin errors++; $display("FAIL guard got drop=%0d sealed=%b len1=%0d stall=%b want 1 01 7 0", drop_cnt, sealed, len1, stall); end
      fifo_full = 2'b00;
      send(9, 1);
      idle(2);
      checks++; if (len2 !== LW'(1)) begin errors++; $display("FAIL guard_switch got len2=%0d want 1", len2); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 1; i <= 9; i++) send(DW'(i), 0);
      send(10, -1);
      checks++; if (len1 !== LW'(9)) begin errors++; $display("FAIL midrst_pre got len1=%0d want 9", len1); end
      @(negedge sysclk); rst = 1'b1; fill_data = 1'b0;
      @(negedge sysclk);
      checks++; if ({wr_en1, wr_en2, stall, sealed} !== 5'b0 || len1 !== '0 || din !== '0 || drop_cnt !== '0) begin errors++; $display("FAIL midrst got wr=%b%b stall=%b sealed=%b len1=%0d din=%0d drop=%0d want all 0", wr_en1, wr_en2, stall, sealed, len1, din, drop_cnt); end
      rst = 1'b0;
      send(11, 0);
      idle(2);
      checks++; if (len1 !== LW'(1)) begin errors++; $display("FAIL midrst_restart got len1=%0d want 1", len1); end
   endtask

   task automatic test_locked();
      do_reset();
      for (int i = 1; i <= 32; i++) send(DW'(i), (i > 16) ? 1 : 0);
      idle(2);
      locked = 1'b0;
      repeat (4) send(16'h5555, -1);
      send(16'h5555, -1);
      bank_release = 2'b01;
      idle(2);
      checks++; if (drop_cnt !== '0 || sealed !== 2'b11 || stall !== 1'b1 || len1 !== LW'(16)) begin errors++; $display("FAIL locked_freeze got drop=%0d sealed=%b stall=%b len1=%0d want 0 11 1 16", drop_cnt, sealed, stall, len1); end
      locked = 1'b1;
      send(16'h5555, -1);
      idle(1);
      checks++; if (drop_cnt !== DRW'(1)) begin errors++; $display("FAIL locked_resume got drop=%0d want 1", drop_cnt); end
   endtask

   task automatic test_release_edge();
      do_reset();
      for (int i = 1; i <= 15; i++) send(DW'(i), 0);
      send(16, 0);
      bank_release = 2'b01;
      idle(1);
      checks++; if (sealed !== 2'b01 || len1 !== LW'(16)) begin errors++; $display("FAIL seal_beats_release got sealed=%b len1=%0d want 01 16", sealed, len1); end
      send(17, 1);
      idle(2);
      @(negedge sysclk); bank_release = 2'b10;
      idle(1);
      checks++; if (sealed !== 2'b01 || len2 !== LW'(1)) begin errors++; $display("FAIL release_unsealed got sealed=%b len2=%0d want 01 1", sealed, len2); end
   endtask

   task automatic test_timeout();
      int e;
      do_reset();
      for (int i = 1; i <= 5; i++) send(DW'(i), 0);
      e = cyc + 1;
      idle(1);
`ifdef PP_TIMEOUT_FLUSH_EN
      while (cyc < e + TMO - 1) @(negedge sysclk);
      checks++; if (sealed !== 2'b00) begin errors++; $display("FAIL timeout_early got sealed=%b want 00", sealed); end
      @(negedge sysclk);
      checks++; if (sealed !== 2'b01 || len1 !== LW'(5) || stall !== 1'b0) begin errors++; $display("FAIL timeout_seal got sealed=%b len1=%0d stall=%b want 01 5 0", sealed, len1, stall); end
      send(6, 1);
      idle(2);
      do_reset();
      for (int i = 1; i <= 5; i++) send(DW'(i), 0);
      e = cyc + 1;
      idle(1);
      while (cyc < e + TMO - 1) @(negedge sysclk);
      send(6, 0);
      idle(2);
      checks++; if (sealed !== 2'b00 || len1 !== LW'(6)) begin errors++; $display("FAIL timeout_suppress got sealed=%b len1=%0d want 00 6", sealed, len1); end
`else
      repeat (10000) @(negedge sysclk);
      checks++; if (sealed !== 2'b00 || len1 !== LW'(5) || e <= 0) begin errors++; $display("FAIL no_timeout got sealed=%b len1=%0d want 00 5", sealed, len1); end
`endif
   endtask

   initial begin
      test_reset();
      test_fill_alternate();
      test_stall_release();
      test_simultaneous();
      test_drop_saturate();
      test_guard();
      test_reset_mid();
      test_locked();
      test_release_edge();
      test_timeout();
      idle(4);
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d pending want 0", sb.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
